// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and next-PC select encoding for the instruction-fetch stage
package fetch_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam int INSTR_BYTES = 4;
  typedef enum logic [1:0] {NPC_SEQ, NPC_HOLD, NPC_BRANCH, NPC_JUMP} npc_sel_e;
endpackage

// File: rtl/ifid_pipe_reg.sv
// ifid_pipe_reg: IF/ID register (instr, pc_plus4, valid) with load, squash-to-NOP and sync reset
module ifid_pipe_reg
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        squash,
  input  logic [31:0] instr,
  input  logic [31:0] pc_plus4,
  output logic [31:0] instr_q,
  output logic [31:0] pc_plus4_q,
  output logic        valid_q
);
  always_ff @(posedge clk) begin
    if (rst || (load && squash)) begin
      instr_q <= NOP_INSTR;
      pc_plus4_q <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      instr_q <= instr;
      pc_plus4_q <= pc_plus4;
      valid_q <= 1'b1;
    end
  end
endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: MIPS IF stage (PC, next-PC select, IF/ID, sticky flags, fetch counter); FETCH_DELAY_SLOT_EN keeps the redirect-cycle word as a delay slot
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter int IMEM_WORDS = 1024
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        stall_in,
  input  logic        branch_taken_in,
  input  logic [31:0] branch_target_in,
  input  logic        jump_in,
  input  logic [31:0] jump_target_in,
  output logic [31:0] pc_out,
  input  logic [31:0] instr_in,
  output logic [31:0] ifid_instr_out,
  output logic [31:0] ifid_pc_plus4_out,
  output logic        ifid_valid_out,
  output logic        misalign_out,
  output logic        addr_err_out,
  output logic [31:0] fetch_count_out
);
  localparam logic [32:0] LIMIT = 33'(IMEM_WORDS) * 33'd4;
  npc_sel_e sel;
  logic [31:0] pc_plus4, target, npc;
  logic redirect, in_range, squash, valid_load;
  always_comb begin
    sel = stall_in ? NPC_HOLD : branch_taken_in ? NPC_BRANCH : jump_in ? NPC_JUMP : NPC_SEQ;
  end
  assign pc_plus4 = pc_out + 32'(INSTR_BYTES);
  assign redirect = sel == NPC_BRANCH || sel == NPC_JUMP;
  assign target = sel == NPC_BRANCH ? branch_target_in : jump_target_in;
  assign npc = sel == NPC_HOLD ? pc_out : redirect ? {target[31:2], 2'b00} : pc_plus4;
  assign in_range = {1'b0, pc_out} < LIMIT;
`ifdef FETCH_DELAY_SLOT_EN
  assign squash = !in_range;
`else
  assign squash = !in_range || redirect;
`endif
  assign valid_load = !stall_in && !squash;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_out <= RESET_PC;
      misalign_out <= 1'b0;
      addr_err_out <= 1'b0;
      fetch_count_out <= '0;
    end else begin
      pc_out <= npc;
      misalign_out <= misalign_out || (redirect && target[1:0] != 2'b00);
      addr_err_out <= addr_err_out || !in_range;
      fetch_count_out <= fetch_count_out + 32'(valid_load);
    end
  end
  ifid_pipe_reg u_ifid (
    .clk(Clk),
    .rst(Reset),
    .load(!stall_in),
    .squash(squash),
    .instr(instr_in),
    .pc_plus4(pc_plus4),
    .instr_q(ifid_instr_out),
    .pc_plus4_q(ifid_pc_plus4_out),
    .valid_q(ifid_valid_out)
  );
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: scoreboard bench driving a large-memory and a 4-word-memory fetch unit from shared stimulus
module tb_fetch_pc_unit;
  typedef struct packed {
    logic [31:0] pc, ins, pp4;
    logic v, mis, aerr;
    logic [31:0] cnt;
  } st_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, stall, br, jmp;
  logic [31:0] bt, jt;
  logic [31:0] pc_a, ins_a, pp4_a, cnt_a, pc_b, ins_b, pp4_b, cnt_b;
  logic v_a, mis_a, aerr_a, v_b, mis_b, aerr_b;
  int n_vec = 0, n_err = 0;
  st_t ma = '0, mb = '0;
  st_t q[$];
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {8'hC3, a[23:0]} ^ 32'h0013_5700;
  endfunction
  fetch_pc_unit #(.RESET_PC(32'h0), .IMEM_WORDS(1024)) dut_a (
    .Clk(clk), .Reset(rst), .stall_in(stall), .branch_taken_in(br), .branch_target_in(bt),
    .jump_in(jmp), .jump_target_in(jt), .pc_out(pc_a), .instr_in(mem(pc_a)),
    .ifid_instr_out(ins_a), .ifid_pc_plus4_out(pp4_a), .ifid_valid_out(v_a),
    .misalign_out(mis_a), .addr_err_out(aerr_a), .fetch_count_out(cnt_a));
  fetch_pc_unit #(.RESET_PC(32'h0), .IMEM_WORDS(4)) dut_b (
    .Clk(clk), .Reset(rst), .stall_in(stall), .branch_taken_in(br), .branch_target_in(bt),
    .jump_in(jmp), .jump_target_in(jt), .pc_out(pc_b), .instr_in(mem(pc_b)),
    .ifid_instr_out(ins_b), .ifid_pc_plus4_out(pp4_b), .ifid_valid_out(v_b),
    .misalign_out(mis_b), .addr_err_out(aerr_b), .fetch_count_out(cnt_b));
  function automatic st_t step(input st_t s, input logic [31:0] lim);
    st_t n;
    logic ok, redir, keep;
    logic [31:0] t;
    n = s;
    ok = s.pc < lim;
    redir = br || jmp;
    t = br ? bt : jt;
`ifdef FETCH_DELAY_SLOT_EN
    keep = ok;
`else
    keep = ok && !redir;
`endif
    if (rst) begin
      n = '0;
    end else begin
      if (!ok) n.aerr = 1'b1;
      if (!stall) begin
        n.ins = keep ? mem(s.pc) : 32'h0;
        n.pp4 = keep ? s.pc + 32'd4 : 32'h0;
        n.v = keep;
        if (keep) n.cnt = s.cnt + 32'd1;
        if (redir && t[1:0] != 2'b00) n.mis = 1'b1;
        n.pc = redir ? {t[31:2], 2'b00} : s.pc + 32'd4;
      end
    end
    return n;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cyc(input logic r, input logic s, input logic b, input logic j,
                     input logic [31:0] btv, input logic [31:0] jtv);
    st_t ea, eb;
    rst = r; stall = s; br = b; jmp = j; bt = btv; jt = jtv;
    ma = step(ma, 32'd4096);
    mb = step(mb, 32'd16);
    q.push_back(ma);
    q.push_back(mb);
    @(posedge clk);
    #1;
    ea = q.pop_front();
    eb = q.pop_front();
    chk("a_pc", pc_a, ea.pc);
    chk("a_instr", ins_a, ea.ins);
    chk("a_pp4", pp4_a, ea.pp4);
    chk("a_valid", 32'(v_a), 32'(ea.v));
    chk("a_misalign", 32'(mis_a), 32'(ea.mis));
    chk("a_addr_err", 32'(aerr_a), 32'(ea.aerr));
    chk("a_count", cnt_a, ea.cnt);
    chk("b_pc", pc_b, eb.pc);
    chk("b_instr", ins_b, eb.ins);
    chk("b_pp4", pp4_b, eb.pp4);
    chk("b_valid", 32'(v_b), 32'(eb.v));
    chk("b_misalign", 32'(mis_b), 32'(eb.mis));
    chk("b_addr_err", 32'(aerr_b), 32'(eb.aerr));
    chk("b_count", cnt_b, eb.cnt);
  endtask
  initial begin
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("reset_pc", pc_a, 32'h0);
    repeat (2) cyc(0, 0, 0, 0, 0, 0);
    chk("pc_at_stall", pc_a, 32'h8);
    repeat (2) cyc(0, 1, 1, 0, 32'h80, 0);
    chk("pc_held", pc_a, 32'h8);
    cyc(0, 0, 0, 0, 0, 0);
    chk("pc_resume", pc_a, 32'hC);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 32'h40, 0);
    chk("branch_pc", pc_a, 32'h40);
    repeat (2) cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 32'h22);
    chk("jump_misaligned_pc", pc_a, 32'h20);
    chk("misalign_set", 32'(mis_a), 32'h1);
    repeat (3) cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 32'h0);
    repeat (6) cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 32'h64, 32'h4);
    chk("branch_wins", pc_a, 32'h64);
    repeat (2) cyc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 60; i++)
      cyc(0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
          32'($urandom_range(0, 255)), 32'($urandom_range(0, 255)));
    cyc(0, 0, 0, 1, 0, 32'h30);
    cyc(1, 1, 1, 0, 32'h80, 0);
    chk("reset_over_redirect", pc_a, 32'h0);
    repeat (5) cyc(0, 0, 0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Instruction-fetch control stage of the MIPS pipeline. Owns the program counter, drives the instruction-memory address, and captures the returned word into the IF/ID pipeline register. Handles sequential increment, branch/jump redirects from ID, load-use stalls, squashing, and address error flags. Sits between the ID-stage hazard/branch logic and the combinational instruction memory.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- IMEM_WORDS, 1024, instruction-memory depth in 32-bit words; valid byte addresses are 0 .. IMEM_WORDS*4-4
- Clk  in  1  pipeline clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high; sampled on rising edge of Clk
- stall_in  in  1  hold PC and IF/ID (load-use hazard)
- branch_taken_in  in  1  ID resolved a taken branch this cycle
- branch_target_in  in  32  branch target byte address
- jump_in  in  1  ID decoded j/jal/jr this cycle
- jump_target_in  in  32  jump target byte address
- pc_out  out  32  current PC, to instruction-memory address
- instr_in  in  32  word returned by instruction memory for pc_out, same cycle
- ifid_instr_out  out  32  IF/ID instruction
- ifid_pc_plus4_out  out  32  IF/ID PC+4 of that instruction
- ifid_valid_out  out  1  IF/ID holds a real instruction
- misalign_out  out  1  sticky: a redirect target had addr[1:0] != 0
- addr_err_out  out  1  sticky: PC left the valid address range
- fetch_count_out  out  32  number of valid instructions loaded into IF/ID

## Operation
- Next-PC priority per edge: Reset > stall_in > branch_taken_in > jump_in > PC+4.
- stall_in=1: PC, IF/ID, and counter hold; any redirect asserted in the same cycle is ignored (ID re-presents it after the stall).
- Redirect (branch or jump, no stall): PC <= target with bits [1:0] forced to 00; if target[1:0] != 0, set misalign_out. The word fetched during the redirect cycle is squashed: IF/ID gets instr=32'h0 (NOP), pc_plus4=0, valid=0.
- Sequential (no stall, no redirect): PC <= PC+4, modulo 2^32. IF/ID <= {instr_in, PC+4, valid=1}.
- Out of range (pc_out >= IMEM_WORDS*4): the fetched word is replaced by NOP and valid=0; addr_err_out is set; PC keeps advancing or redirecting normally so a redirect can recover.
- fetch_count_out increments by 1 on each edge that loads IF/ID with valid=1 and wraps at 2^32.
- Sticky flags clear only on Reset.

## Timing
- Reset values: pc_out=RESET_PC, ifid_instr_out=0, ifid_pc_plus4_out=0, ifid_valid_out=0, misalign_out=0, addr_err_out=0, fetch_count_out=0.
- pc_out is registered. instr_in is combinational on pc_out and is captured at the next edge, so IF/ID has 1-cycle latency from pc_out.
- Redirect latency: target appears on pc_out 1 cycle after the redirect cycle. Its instruction reaches IF/ID 2 cycles after the redirect cycle, with 1 squashed bubble between.
- Reset asserted mid-stream overrides stall and redirect on the same edge. The first fetch after release is at RESET_PC.
- Simultaneous branch_taken_in and jump_in: branch target wins; there is no error.

## Configuration
- FETCH_DELAY_SLOT_EN defined: MIPS branch delay slot. On a redirect, the word fetched in the redirect cycle is loaded into IF/ID as valid (sequential rules, counted). There is no bubble.
- Undefined: that word is squashed to a NOP bubble as described above.

## Structure
- Shared package fetch_pkg: NOP_INSTR constant (32'h0), default RESET_PC, INSTR_BYTES=4, and next-PC select enum {NPC_SEQ, NPC_HOLD, NPC_BRANCH, NPC_JUMP}.
- One sub-module: ifid_pipe_reg. It holds the IF/ID instruction, pc_plus4, and valid fields, with load, squash, and sync reset inputs. The PC, next-PC select, flags, and counter stay in fetch_pc_unit.

## Test plan
- Reset then 4 free-running cycles with instr_in=memory model: pc_out 0,4,8,12. IF/ID valid from cycle 2 with pc_plus4 4,8,12. fetch_count_out=3 after 4 edges.
- stall_in high 2 cycles at PC=8: pc_out stays 8, IF/ID unchanged, counter unchanged. It resumes at 12 after release.
- branch_taken_in with target 0x40 at PC=0x10: pc_out=0x40 next cycle, IF/ID valid=0 one cycle. With FETCH_DELAY_SLOT_EN, the 0x10 word is valid instead.
- jump target 0x22 (misaligned): pc_out=0x20 and misalign_out=1, which stays high until Reset.
- IMEM_WORDS=4 with free run: at pc_out=0x10, addr_err_out=1 and IF/ID valid=0. A jump to 0x0 resumes valid fetch.
- Reset asserted together with branch_taken_in and stall_in at PC=0x30: next pc_out=RESET_PC and all outputs are at their reset values.
